// File: rtl/rr_mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_sel_arbiter
// Description : Four-channel round-robin arbiter with bounded dwell; drives the
//               2-bit select of the downstream 4:1 mux plus grant/valid/busy.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_sel_arbiter #(
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [CW-1:0] c_dwell_m1 = CW'(DWELL - 1);

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_sel, w_sel_nxt;
  logic [1:0]    r_last, w_last_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]    w_pick;
  logic          w_any;
  logic          w_release;

  // Scan from farthest to nearest so the nearest requester after r_last wins;
  // the default covers the case where only r_last itself is requesting.
  always_comb begin
    w_pick = r_last;
    for (int k = 3; k >= 1; k--) begin
      if (req[r_last + 2'(k)]) begin
        w_pick = r_last + 2'(k);
      end
    end
  end

  assign w_any     = |req;
  assign w_release = (r_cnt == '0) || !req[r_sel] || !en;

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (en && w_any) begin
          w_state_nxt = S_GRANT;
          w_sel_nxt   = w_pick;
          w_last_nxt  = w_pick;
          w_cnt_nxt   = c_dwell_m1;
        end
      end
      S_GRANT: begin
        if (!w_release) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else if (en && w_any) begin
          // Handover in the same edge keeps valid high with no bubble.
          w_sel_nxt  = w_pick;
          w_last_nxt = w_pick;
          w_cnt_nxt  = c_dwell_m1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sel   <= 2'd0;
      r_last  <= 2'd3;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign sel   = r_sel;
  assign valid = (r_state == S_GRANT);
  assign busy  = valid;
  assign grant = valid ? (4'b0001 << r_sel) : 4'b0000;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_mux_sel_arbiter
// Description : Scoreboard bench for rr_mux_sel_arbiter at DWELL = 4, 2 and 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux_sel_arbiter;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b1;
  logic [3:0] req   = 4'b1111;

  logic [1:0] sel_w   [3];
  logic [3:0] grant_w [3];
  logic       valid_w [3];
  logic       busy_w  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DW = (g == 0) ? 4 : ((g == 1) ? 2 : 1);
    rr_mux_sel_arbiter #(.DWELL(DW), .CW(8)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .req   (req),
      .sel   (sel_w[g]),
      .grant (grant_w[g]),
      .valid (valid_w[g]),
      .busy  (busy_w[g])
    );
  end

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] grant;
    logic       valid;
  } exp_t;

  exp_t       sb[$];
  int         passes = 0;
  int         total  = 0;
  int         dw[3]  = '{4, 2, 1};
  logic       m_valid[3];
  logic [1:0] m_sel[3];
  logic [1:0] m_last[3];
  int         m_cnt[3];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    assert (obs === exp_v) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 1'b0;
      m_sel[i]   = 2'd0;
      m_last[i]  = 2'd3;
      m_cnt[i]   = 0;
    end
  endtask

  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] idx;
      idx = 2'((int'(last) + k) % 4);
      if (r[idx]) return idx;
    end
    return last;
  endfunction

  // Reference behaviour for one edge, then queue what each DUT must show.
  task automatic model_step(input logic e, input logic [3:0] r);
    for (int i = 0; i < 3; i++) begin
      if (m_valid[i] && e && r[m_sel[i]] && m_cnt[i] > 0) begin
        m_cnt[i]--;
      end else if (e && (r != 4'b0000)) begin
        m_sel[i]   = rr_pick(m_last[i], r);
        m_last[i]  = m_sel[i];
        m_cnt[i]   = dw[i] - 1;
        m_valid[i] = 1'b1;
      end else begin
        m_valid[i] = 1'b0;
      end
      sb.push_back('{m_sel[i], (m_valid[i] ? (4'b0001 << m_sel[i]) : 4'b0000), m_valid[i]});
    end
  endtask

  task automatic tick(input logic e, input logic [3:0] r);
    exp_t x;
    @(negedge clk);
    en  = e;
    req = r;
    model_step(e, r);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      x = sb.pop_front();
      chk($sformatf("sel[%0d]", i),   8'(sel_w[i]),   8'(x.sel));
      chk($sformatf("grant[%0d]", i), 8'(grant_w[i]), 8'(x.grant));
      chk($sformatf("valid[%0d]", i), 8'(valid_w[i]), 8'(x.valid));
      chk($sformatf("busy[%0d]", i),  8'(busy_w[i]),  8'(x.valid));
    end
  endtask

  task automatic chk_reset(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_sel[%0d]", tag, i),   8'(sel_w[i]),   8'h00);
      chk($sformatf("%s_grant[%0d]", tag, i), 8'(grant_w[i]), 8'h00);
      chk($sformatf("%s_valid[%0d]", tag, i), 8'(valid_w[i]), 8'h00);
      chk($sformatf("%s_busy[%0d]", tag, i),  8'(busy_w[i]),  8'h00);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1;
    chk_reset("rst");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Full rotation with everyone requesting.
    for (int i = 0; i < 17; i++) begin
      tick(1'b1, 4'b1111);
      chk("rot_dw4_sel", 8'(sel_w[0]), 8'((i / 4) % 4));
      chk("rot_dw1_sel", 8'(sel_w[2]), 8'(i % 4));
      chk("rot_dw4_valid", 8'(valid_w[0]), 8'h01);
    end
    tick(1'b0, 4'b0000);
    chk("idle_valid", 8'(valid_w[0]), 8'h00);

    // Early release of a ch2 grant.
    tick(1'b1, 4'b0100);
    tick(1'b1, 4'b0100);
    tick(1'b1, 4'b0000);
    chk("early_valid", 8'(valid_w[0]), 8'h00);
    chk("early_grant", 8'(grant_w[0]), 8'h00);
    chk("early_sel",   8'(sel_w[0]),   8'h02);

    // Fairness between ch0 and ch3 (last granted was ch2, so ch3 leads).
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 4'b1001);
      chk("fair_dw2_sel", 8'(sel_w[1]), ((i / 2) % 2 == 0) ? 8'h03 : 8'h00);
    end
    tick(1'b0, 4'b0000);

    // Enable drop mid-grant on ch1, then re-enable.
    tick(1'b1, 4'b0010);
    tick(1'b1, 4'b0010);
    tick(1'b0, 4'b0010);
    chk("endrop_valid", 8'(valid_w[0]), 8'h00);
    tick(1'b1, 4'b0010);
    chk("regrant_sel",   8'(sel_w[0]),   8'h01);
    chk("regrant_valid", 8'(valid_w[0]), 8'h01);
    for (int i = 0; i < 4; i++) tick(1'b1, 4'b0010);
    chk("regrant_hold", 8'(grant_w[0]), 8'h02);

    // Asynchronous reset during a ch3 grant.
    tick(1'b1, 4'b1000);
    tick(1'b1, 4'b1000);
    chk("pre_arst_sel", 8'(sel_w[0]), 8'h03);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("arst");
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick(1'b1, 4'b1111);
    chk("post_arst_grant", 8'(grant_w[0]), 8'h01);
    tick(1'b1, 4'b1111);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_mux_sel_arbiter.md
# rr_mux_sel_arbiter

Round-robin select generator that sits directly upstream of the 1-bit 4:1 mux stage and drives its 2-bit select. It samples four channel request lines and grants one channel at a time for a bounded dwell period. Requests are served in rotating priority, so no requester starves. It presents the winning index on `sel`, which connects straight to the mux select, plus a one-hot `grant` and a `valid` qualifier for the mux output.

## Interface
- `DWELL`, default 4: maximum cycles a single grant lasts. Legal range is 1..255.
- `CW`, default 8: width of the dwell counter. Must satisfy 2^CW > DWELL.
- `clk`  input  1  rising-edge clock for all state.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `en`  input  1  arbitration enable. Low forces release and holds IDLE.
- `req`  input  4  per-channel request; bit i corresponds to mux input i (a=0, b=1, c=2, d=3).
- `sel`  output  2  granted channel index; connects to mux `s`.
- `grant`  output  4  one-hot grant, equal to `1 << sel` while valid, else 0.
- `valid`  output  1  high while a grant is active, i.e. the mux output is meaningful.
- `busy`  output  1  high when FSM is in GRANT; identical to `valid`, provided for bus status.

## Operation
- FSM has two states: IDLE and GRANT.
- Internal registers:
  - `last[1:0]`: index of the most recently granted channel.
  - `cnt[CW-1:0]`: remaining dwell cycles.
- Rotating pick: search `req` starting at `last+1` (mod 4), then `last+2`, `last+3`, `last`. The first set bit wins. This means the current holder is re-picked only if no other channel requests.
- IDLE, and `en`=1 with `|req`=1 at an edge:
  - `sel` and `last` take the picked index; `grant`/`valid`/`busy` assert.
  - `cnt` loads DWELL-1.
  - FSM moves to GRANT.
- IDLE otherwise: stay. `sel` holds its last value so the mux input stays stable; `grant`=0, `valid`=0.
- GRANT: at each edge the release condition is `cnt`==0 OR `req[sel]`==0 OR `en`==0.
  - No release: `cnt` decrements; `sel` and `grant` are unchanged.
  - Release with `en`=1 and `|req`=1: pick the next channel in the same edge (no bubble cycle). Update `sel`, `last`, `grant`, reload `cnt`=DWELL-1, stay in GRANT.
  - Release otherwise: go to IDLE; `grant`=0, `valid`=0, `sel` held.
- DWELL=1: every grant lasts exactly one cycle. With all four requesting, `sel` cycles 0,1,2,3,0… every clock.
- `cnt` never underflows; it is only decremented when nonzero.
- Reset value of every output and register: `sel`=0, `grant`=0000, `valid`=0, `busy`=0, `cnt`=0, `last`=3 (so channel 0 has first priority), FSM=IDLE.

## Timing
- `req` and `en` are sampled at the rising edge. Outputs are registered and change one edge after the sampled condition; there is no combinational path from input to output.
- Grant latency: `req` rises before edge N, so `valid` is high from edge N onward.
- Maximum grant length is DWELL cycles. Early drop: if `req[sel]` falls before edge M, the grant ends at edge M.
- Handover between channels takes zero idle cycles. `valid` stays high across the handover and only `sel`/`grant` change.
- Reset asserted mid-grant: all outputs go to their reset values immediately, without waiting for a clock edge. After `rst_n` rises, the first grant again starts searching from channel 0.
- Simultaneous release and new request on the same edge are resolved in that edge as described above.

## Test plan
- Reset: assert `rst_n`=0 with `req`=1111 → `sel`=00, `grant`=0000, `valid`=0. Release reset with `en`=1 → next edge `sel`=00, `grant`=0001, `valid`=1.
- Full rotation, DWELL=4, `req`=1111 held → `sel` holds 0 for 4 cycles, then 1, 2, 3 for 4 cycles each, then 0 again. `valid` stays 1 continuously.
- Early release: grant on ch2 (`req`=0100), drop `req[2]` after 2 cycles → next edge `valid`=0, `grant`=0000, `sel` stays 10.
- Fairness: `req`=1001 held, DWELL=2 → `sel` sequence 0,0,3,3,0,0,3,3… Channels 1 and 2 are never granted.
- `en` drop mid-grant on ch1 → next edge `valid`=0. Re-enable with `req`=0010 → ch1 is re-granted (sole requester), `cnt` reloaded to full DWELL.
- Async reset mid-grant: pulse `rst_n` low between edges during a ch3 grant → outputs reach their reset values before the next edge. The first grant after reset is ch0 when `req`=1111.
